fdiv_scheduler: RTL and testbench
=================================

Name: fdiv_scheduler

Overview:
- Round-robin scheduler that shares one iterative single-precision float divider core among N_REQ requesters.
- Accepts requests over valid/ready handshakes and latches the operands.
- Issues each operation to the core, captures the quotient, and returns it tagged with the requester ID.
- Resolves zero-divisor cases locally (the core ignores them), and a watchdog guarantees every accepted request gets a response.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width, equal to clog2(N_REQ)
- TIMEOUT, 64, cycles in WAIT before the watchdog aborts (must exceed core latency, about 28)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept (one-hot, at most one bit set)
- req_a  in  N_REQ*32  dividends, slot i at [32i+31:32i]
- req_b  in  N_REQ*32  divisors, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  index of the requester that owns the response
- rsp_result  out  32  IEEE-754 quotient
- rsp_err  out  1  1 = divide-by-zero or watchdog abort
- div_start  out  1  one-cycle start pulse to the core
- div_a  out  32  dividend to the core
- div_b  out  32  divisor to the core
- div_result  in  32  core quotient, valid only in the div_done cycle
- div_done  in  1  core completion pulse
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE and the round-robin pointer is 0.
  - All outputs are 0: req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, div_start, div_a, div_b, busy.
  - Reset asserted mid-operation aborts silently with no response. The core is reset by the same rst_n.
- States: IDLE, ISSUE, WAIT, RESP. State is encoded in 2 bits with unique codes.
- IDLE:
  - Arbitrate among the set req_valid bits, starting the search at the pointer and wrapping modulo N_REQ.
  - The winner i gets req_ready[i]=1 combinationally in the same cycle; the handshake completes that cycle.
  - Latch req_a[i], req_b[i] and id=i. Set pointer to (i+1) mod N_REQ.
  - If no request is valid: stay in IDLE and hold the pointer.
- Zero divisor, checked at accept time on b[30:0]==0:
  - Do not start the core; go directly to RESP with rsp_err=1.
  - If a[30:0]==0, the result is 0x7FC00000 (NaN).
  - Otherwise the result is {a[31]^b[31], 8'hFF, 23'h0} (±Inf).
  - Otherwise (non-zero divisor): go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle; clear the watchdog counter; go to WAIT.
- div_a and div_b are driven from the latched operands and held stable from ISSUE until leaving WAIT.
- WAIT:
  - The counter increments each cycle.
  - When div_done=1: capture div_result into rsp_result, set rsp_err=0, go to RESP.
  - When counter==TIMEOUT-1 and no div_done: set rsp_result=0x7FC00000, rsp_err=1, go to RESP.
  - div_done seen outside WAIT is ignored.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_result and rsp_err held stable until rsp_ready.
  - On the handshake cycle: go to IDLE; rsp_valid deasserts the next cycle.
  - req_ready stays 0 throughout RESP, so there is no accept in the handshake cycle.
- Throughput is one operation in flight. There is always at least 1 idle cycle on the core between a done and the next start.
- Latency from request accept to rsp_valid:
  - core latency + 2 cycles for normal operations;
  - 1 cycle for zero divisor.
- Fairness: with all requesters continuously valid, grants go 0,1,2,3,0,...
- Requesters must hold req_valid and operands until req_ready; deasserting req_valid earlier is legal and loses no state.

Decomposition:
- Package fdiv_pkg holds:
  - state enum;
  - constants FP_QNAN=32'h7FC00000, FP_EXP_ALL1=8'hFF;
  - function fp_is_zero(x), meaning x[30:0]==0.
- Sub-module rr_arbiter (N_REQ, combinational grant from req and pointer, registered pointer update on an enable). It is reusable by other shared-unit schedulers.

Test Plan:
- Single request: requester 2 sends a=0x40C00000 (6.0), b=0x40000000 (2.0); model core done after 28 cycles with 0x40400000 -> rsp_id=2, rsp_result=0x40400000, rsp_err=0, exactly one div_start pulse.
- All 4 requesters valid continuously, 8 operations -> grant order 0,1,2,3,0,1,2,3; each rsp_id matches its operands; req_ready is one-hot at all times.
- Zero divisor: a=0xC0000000, b=0x00000000 -> rsp_result=0xFF800000, rsp_err=1, div_start never pulses; a=0x80000000, b=0x80000000 -> 0x7FC00000, rsp_err=1.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_* stable, no req_ready pulses; release -> next grant follows in IDLE.
- Watchdog: core never asserts done -> rsp_valid exactly TIMEOUT cycles after ISSUE with 0x7FC00000, rsp_err=1; a later done pulse is ignored.
- Reset mid-WAIT: drop rst_n -> all outputs 0 asynchronously; after release, a new request is served with pointer restarting at 0.

Source files
------------

// File: rtl/fdiv_pkg.sv
// Shared types and IEEE-754 helpers for the
// divider scheduler slice.
package fdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] result;
    logic        err;
  } rsp_t;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [7:0]  FP_EXP_ALL1 = 8'hFF;

  function automatic logic fp_is_zero(
    input logic [31:0] x
  );
    return x[30:0] == 31'd0;
  endfunction

  // 0/0 is NaN, x/0 is signed infinity
  function automatic rsp_t fp_div0(
    input logic [31:0] a,
    input logic [31:0] b
  );
    rsp_t r;
    r.err = 1'b1;
    if (fp_is_zero(a))
      r.result = FP_QNAN;
    else
      r.result = {a[31] ^ b[31],
                  FP_EXP_ALL1, 23'd0};
    return r;
  endfunction

endpackage

// File: rtl/fdiv_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational grant from
// the request vector, pointer advances on enable.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             any
);

  logic [ID_W-1:0] ptr;

  function automatic int wrap(input int x);
    return (x >= N_REQ) ? x - N_REQ : x;
  endfunction

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && req[wrap(int'(ptr) + k)]) begin
        any      = 1'b1;
        grant_id = ID_W'(wrap(int'(ptr) + k));
      end
    end
    if (any)
      grant[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (en && any)
      ptr <= ID_W'(wrap(int'(grant_id) + 1));
  end

endmodule

// File: rtl/fdiv_scheduler.sv
// Shares one iterative float divider among N_REQ
// requesters with round-robin arbitration.
module fdiv_scheduler
  import fdiv_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*32-1:0] req_a,
  input  logic [N_REQ*32-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [31:0]         rsp_result,
  output logic                rsp_err,
  output logic                div_start,
  output logic [31:0]         div_a,
  output logic [31:0]         div_b,
  input  logic [31:0]         div_result,
  input  logic                div_done,
  output logic                busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t state, state_nx;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gid;
  logic             any;
  logic             accept;
  logic [31:0]      win_a;
  logic [31:0]      win_b;
  logic             win_b0;
  rsp_t             z_rsp;

  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [ID_W-1:0]  id_q;
  logic [31:0]      res_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt;
  logic             wd_hit;

  assign accept = (state == ST_IDLE) && any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .en       (accept),
    .grant    (grant),
    .grant_id (gid),
    .any      (any)
  );

  assign win_a  = req_a[32*gid +: 32];
  assign win_b  = req_b[32*gid +: 32];
  assign win_b0 = fp_is_zero(win_b);
  assign z_rsp  = fp_div0(win_a, win_b);
  assign wd_hit = cnt == CNT_W'(TIMEOUT - 1);

  assign req_ready  = (state == ST_IDLE) ? grant : '0;
  assign busy       = state != ST_IDLE;
  assign div_start  = state == ST_ISSUE;
  assign rsp_valid  = state == ST_RESP;
  assign div_a      = a_q;
  assign div_b      = b_q;
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (any)
          state_nx = win_b0 ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (div_done || wd_hit)
          state_nx = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready)
          state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      if (accept) begin
        a_q  <= win_a;
        b_q  <= win_b;
        id_q <= gid;
        if (win_b0) begin
          res_q <= z_rsp.result;
          err_q <= z_rsp.err;
        end
      end
      if (state == ST_ISSUE)
        cnt <= '0;
      if (state == ST_WAIT) begin
        cnt <= cnt + 1'b1;
        // a real completion wins over a same-cycle timeout
        if (div_done) begin
          res_q <= div_result;
          err_q <= 1'b0;
        end else if (wd_hit) begin
          res_q <= FP_QNAN;
          err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fdiv_scheduler.sv
// Directed scoreboard bench for fdiv_scheduler
// with a fixed-latency model of the divider core.
module tb_fdiv_scheduler;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 64;
  localparam int LAT = 28;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_err;
  logic            div_start;
  logic [31:0]     div_a;
  logic [31:0]     div_b;
  logic [31:0]     div_result;
  logic            div_done;
  logic            busy;

  fdiv_scheduler #(
    .N_REQ   (N),
    .ID_W    (IDW),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .div_start  (div_start),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_result (div_result),
    .div_done   (div_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    res;
    logic           err;
    int             acc;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   starts = 0;
  logic prev_valid = 1'b0;
  logic [IDW+32:0] hold;

  logic [31:0] op_a[N];
  logic [31:0] op_b[N];
  int          left[N];

  logic core_en = 1'b1;
  logic inject = 1'b0;
  int   core_cnt = 0;

  function automatic logic [31:0] core_fn(
    input logic [31:0] a,
    input logic [31:0] b
  );
    if (a == 32'h40C00000 && b == 32'h40000000)
      return 32'h40400000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h13579BDF;
  endfunction

  always begin
    @(posedge clk);
    #2;
    div_done = 1'b0;
    if (!rst_n) begin
      core_cnt = 0;
    end else begin
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0 && core_en) begin
          div_done   = 1'b1;
          div_result = core_fn(div_a, div_b);
        end
      end
      if (inject) begin
        div_done   = 1'b1;
        div_result = 32'h3F800000;
      end
      if (div_start)
        core_cnt = LAT;
    end
  end

  function automatic exp_t expect_for(
    input int i,
    input logic [31:0] a,
    input logic [31:0] b
  );
    exp_t e;
    e.id  = IDW'(i);
    e.acc = cyc;
    if (b[30:0] == 31'd0) begin
      e.err = 1'b1;
      e.lat = 1;
      if (a[30:0] == 31'd0) e.res = 32'h7FC00000;
      else e.res = {a[31] ^ b[31], 8'hFF, 23'd0};
    end else if (core_en) begin
      e.err = 1'b0;
      e.lat = LAT + 2;
      e.res = core_fn(a, b);
    end else begin
      e.err = 1'b1;
      e.lat = TO + 2;
      e.res = 32'h7FC00000;
    end
    return e;
  endfunction

  task automatic drive(input int i);
    req_a[32*i +: 32] = op_a[i];
    req_b[32*i +: 32] = op_b[i];
  endtask

  task automatic send(
    input int i,
    input logic [31:0] a,
    input logic [31:0] b,
    input int n
  );
    op_a[i] = a;
    op_b[i] = b;
    left[i] = n;
    drive(i);
    req_valid[i] = 1'b1;
  endtask

  task automatic step();
    logic [N-1:0] hs;
    exp_t e;
    @(negedge clk);
    cyc++;
    tests++;
    assert ($countones(req_ready) <= 1 &&
            !(busy && req_ready != '0))
    else begin
      fails++;
      $error("FAIL ready_onehot got=%b busy=%b",
             req_ready, busy);
    end
    if (div_start) starts++;
    if (rsp_valid && !prev_valid) begin
      tests++;
      assert (sb.size() != 0 &&
              cyc - sb[0].acc == sb[0].lat)
      else begin
        fails++;
        $error("FAIL latency got=%0d exp=%0d q=%0d",
               sb.size() ? cyc - sb[0].acc : -1,
               sb.size() ? sb[0].lat : -1, sb.size());
      end
      hold = {rsp_id, rsp_result, rsp_err};
    end else if (rsp_valid) begin
      tests++;
      assert ({rsp_id, rsp_result, rsp_err} === hold)
      else begin
        fails++;
        $error("FAIL rsp_stable got=%h exp=%h",
               {rsp_id, rsp_result, rsp_err}, hold);
      end
    end
    if (rsp_valid && rsp_ready && sb.size() != 0) begin
      e = sb.pop_front();
      tests++;
      assert (rsp_id === e.id)
      else begin
        fails++;
        $error("FAIL rsp_id got=%0d exp=%0d",
               rsp_id, e.id);
      end
      tests++;
      assert (rsp_result === e.res)
      else begin
        fails++;
        $error("FAIL rsp_result got=%h exp=%h",
               rsp_result, e.res);
      end
      tests++;
      assert (rsp_err === e.err)
      else begin
        fails++;
        $error("FAIL rsp_err got=%b exp=%b",
               rsp_err, e.err);
      end
    end
    prev_valid = rsp_valid;
    hs = req_valid & req_ready;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        sb.push_back(expect_for(i, op_a[i], op_b[i]));
        grants.push_back(i);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        left[i]--;
        if (left[i] > 0) begin
          op_a[i] = $urandom;
          op_b[i] = $urandom | 32'h40000000;
          drive(i);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic run_until_done(input int max);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((req_valid != '0 || busy ||
                sb.size() != 0) && n < max);
    tests++;
    assert (n < max)
    else begin
      fails++;
      $error("FAIL drain_timeout got=%0d exp<%0d",
             n, max);
    end
  endtask

  task automatic step_until_valid(input int max);
    int n;
    n = 0;
    while (!rsp_valid && n < max) begin
      step();
      n++;
    end
    tests++;
    assert (rsp_valid === 1'b1)
    else begin
      fails++;
      $error("FAIL wait_rsp got=%b exp=1", rsp_valid);
    end
  endtask

  task automatic check_grants(input int exp[$]);
    tests++;
    assert (grants == exp)
    else begin
      fails++;
      $error("FAIL grant_order got=%p exp=%p",
             grants, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b1;
    div_result = '0;
    div_done   = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
      left[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    assert ({req_ready, rsp_valid, rsp_id, rsp_result,
             rsp_err, div_start, div_a, div_b,
             busy} === '0)
    else begin
      fails++;
      $error("FAIL reset_outputs got=%b", {req_ready,
             rsp_valid, rsp_id, rsp_result, rsp_err,
             div_start, div_a, div_b, busy});
    end
    rst_n = 1'b1;

    // 6.0 / 2.0 from requester 2
    starts = 0;
    send(2, 32'h40C00000, 32'h40000000, 1);
    run_until_done(200);
    tests++;
    assert (starts == 1)
    else begin
      fails++;
      $error("FAIL single_starts got=%0d exp=1", starts);
    end

    // zero divisors: -2/0 then -0/-0
    starts = 0;
    send(3, 32'hC0000000, 32'h00000000, 1);
    run_until_done(50);
    send(3, 32'h80000000, 32'h80000000, 1);
    run_until_done(50);
    tests++;
    assert (starts == 0)
    else begin
      fails++;
      $error("FAIL zero_starts got=%0d exp=0", starts);
    end

    // fairness with everyone asserting
    grants.delete();
    for (int i = 0; i < N; i++)
      send(i, 32'h3F800000 + i, 32'h40400000 + i, 2);
    run_until_done(1000);
    check_grants('{0, 1, 2, 3, 0, 1, 2, 3});

    // backpressure on the response
    grants.delete();
    rsp_ready = 1'b0;
    send(1, 32'h41200000, 32'h40A00000, 1);
    send(2, 32'h42000000, 32'h41000000, 1);
    step_until_valid(100);
    repeat (10) step();
    rsp_ready = 1'b1;
    run_until_done(200);
    check_grants('{1, 2});

    // watchdog, then stray done pulses
    core_en   = 1'b0;
    rsp_ready = 1'b0;
    starts    = 0;
    send(0, 32'h40800000, 32'h40000000, 1);
    step_until_valid(200);
    inject = 1'b1;
    step();
    inject = 1'b0;
    repeat (2) step();
    rsp_ready = 1'b1;
    run_until_done(50);
    inject = 1'b1;
    step();
    inject = 1'b0;
    repeat (3) step();
    tests++;
    assert (!busy && !rsp_valid && starts == 1)
    else begin
      fails++;
      $error("FAIL wd_quiet got=%b%b/%0d exp=00/1",
             busy, rsp_valid, starts);
    end
    core_en = 1'b1;

    // reset mid-WAIT, pointer was left at 2
    starts = 0;
    send(1, 32'h40000000, 32'h3F800000, 1);
    while (starts == 0 && cyc < 5000) step();
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    assert ({req_ready, rsp_valid, rsp_id, rsp_result,
             rsp_err, div_start, div_a, div_b,
             busy} === '0)
    else begin
      fails++;
      $error("FAIL async_reset got=%b", {req_ready,
             rsp_valid, rsp_id, rsp_result, rsp_err,
             div_start, div_a, div_b, busy});
    end
    sb.delete();
    req_valid  = '0;
    prev_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    grants.delete();
    send(1, 32'h40E00000, 32'h40400000, 1);
    send(3, 32'hC1000000, 32'h40800000, 1);
    run_until_done(300);
    check_grants('{1, 3});

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
